// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: latches an execute op, runs one data-memory access and hands the result
// to writeback. Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses with err.
module lsu_mem_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_read,
  input  logic            in_write,
  input  logic            in_reg_wen,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  output logic            req_wen,
  output logic [XLEN-1:0] req_wdata,
  output logic [3:0]      req_wmask,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_rd_wen,
  output logic            err
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StOut} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              req_valid_q, req_valid_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              req_wen_q, req_wen_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [3:0]        req_wmask_q, req_wmask_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              out_rd_wen_q, out_rd_wen_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              read_q, read_d;
  logic              reg_wen_q, reg_wen_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              illegal;
  logic              misalign;
  logic [3:0]        lane_mask;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   load_val;
  logic              timeout_hit;

  always_comb begin
    illegal = (in_read & in_write) | (in_size == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = (in_read | in_write) &
               (((in_size == 2'b01) & in_result[0]) |
                ((in_size == 2'b10) & (in_result[1:0] != 2'b00)));
`else
    misalign = 1'b0;
`endif
    unique case (in_size)
      2'b00:   lane_mask = 4'b0001 << in_result[1:0];
      2'b01:   lane_mask = 4'b0011 << in_result[1:0];
      default: lane_mask = 4'b1111;
    endcase

    sh = resp_rdata >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'b00:   load_val = uns_q ? {{(XLEN-8){1'b0}}, sh[7:0]} : {{(XLEN-8){sh[7]}}, sh[7:0]};
      2'b01:   load_val = uns_q ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                : {{(XLEN-16){sh[15]}}, sh[15:0]};
      default: load_val = sh;
    endcase

    // Fires on the cycle whose increment would bring the count to TIMEOUT_CYC.
    timeout_hit = (TIMEOUT_CYC != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYC);
  end

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    req_wen_d    = req_wen_q;
    req_wdata_d  = req_wdata_q;
    req_wmask_d  = req_wmask_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_rd_wen_d = out_rd_wen_q;
    err_d        = err_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    read_d       = read_q;
    reg_wen_d    = reg_wen_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          addr_d     = in_result;
          size_d     = in_size;
          uns_d      = in_unsigned;
          read_d     = in_read;
          reg_wen_d  = in_reg_wen;
          if (illegal || misalign) begin
            state_d      = StOut;
            out_valid_d  = 1'b1;
            out_data_d   = in_result;
            out_rd_wen_d = 1'b0;
            err_d        = 1'b1;
          end else if (!in_read && !in_write) begin
            state_d      = StOut;
            out_valid_d  = 1'b1;
            out_data_d   = in_result;
            out_rd_wen_d = in_reg_wen;
            err_d        = 1'b0;
          end else begin
            state_d     = StReq;
            req_valid_d = 1'b1;
            req_addr_d  = {in_result[XLEN-1:2], 2'b00};
            req_wen_d   = in_write;
            req_wmask_d = in_write ? lane_mask : 4'b0000;
            req_wdata_d = in_wdata << {in_result[1:0], 3'b000};
            cnt_d       = '0;
          end
        end
      end
      StReq, StResp: begin
        cnt_d = cnt_q + CntW'(1);
        // A response arriving with the timeout still completes the access.
        if ((state_q == StResp) && resp_valid) begin
          state_d      = StOut;
          out_valid_d  = 1'b1;
          out_data_d   = read_q ? load_val : addr_q;
          out_rd_wen_d = read_q & reg_wen_q;
          err_d        = 1'b0;
        end else if (timeout_hit) begin
          state_d      = StOut;
          req_valid_d  = 1'b0;
          out_valid_d  = 1'b1;
          out_data_d   = '0;
          out_rd_wen_d = 1'b0;
          err_d        = 1'b1;
        end else if ((state_q == StReq) && req_ready) begin
          state_d     = StResp;
          req_valid_d = 1'b0;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          err_d       = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b1;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_wen_q    <= 1'b0;
      req_wdata_q  <= '0;
      req_wmask_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rd_wen_q <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      read_q       <= 1'b0;
      reg_wen_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_wen_q    <= req_wen_d;
      req_wdata_q  <= req_wdata_d;
      req_wmask_q  <= req_wmask_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rd_wen_q <= out_rd_wen_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      read_q       <= read_d;
      reg_wen_q    <= reg_wen_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign req_valid  = req_valid_q;
  assign req_addr   = req_addr_q;
  assign req_wen    = req_wen_q;
  assign req_wdata  = req_wdata_q;
  assign req_wmask  = req_wmask_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_rd_wen = out_rd_wen_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a default instance plus a TIMEOUT_CYC=4 instance on shared inputs.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_read, in_write, in_reg_wen, in_unsigned;
  logic [31:0] in_result, in_wdata, resp_rdata;
  logic [1:0]  in_size;
  logic        req_ready, resp_valid, out_ready;

  logic        a_in_ready, a_req_valid, a_req_wen, a_out_valid, a_out_rd_wen, a_err;
  logic [31:0] a_req_addr, a_req_wdata, a_out_data;
  logic [3:0]  a_req_wmask;
  logic        b_in_ready, b_req_valid, b_req_wen, b_out_valid, b_out_rd_wen, b_err;
  logic [31:0] b_req_addr, b_req_wdata, b_out_data;
  logic [3:0]  b_req_wmask;

  // Monitor view selects which instance the checks look at.
  logic        use_to;
  logic        m_in_ready, m_req_valid, m_req_wen, m_out_valid, m_out_rd_wen, m_err;
  logic [31:0] m_req_addr, m_req_wdata, m_out_data;
  logic [3:0]  m_req_wmask;

  assign m_in_ready   = use_to ? b_in_ready   : a_in_ready;
  assign m_req_valid  = use_to ? b_req_valid  : a_req_valid;
  assign m_req_wen    = use_to ? b_req_wen    : a_req_wen;
  assign m_req_addr   = use_to ? b_req_addr   : a_req_addr;
  assign m_req_wdata  = use_to ? b_req_wdata  : a_req_wdata;
  assign m_req_wmask  = use_to ? b_req_wmask  : a_req_wmask;
  assign m_out_valid  = use_to ? b_out_valid  : a_out_valid;
  assign m_out_data   = use_to ? b_out_data   : a_out_data;
  assign m_out_rd_wen = use_to ? b_out_rd_wen : a_out_rd_wen;
  assign m_err        = use_to ? b_err        : a_err;

  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_result(in_result), .in_wdata(in_wdata),
    .in_read(in_read), .in_write(in_write), .in_reg_wen(in_reg_wen), .in_size(in_size),
    .in_unsigned(in_unsigned),
    .req_valid(a_req_valid), .req_ready(req_ready), .req_addr(a_req_addr), .req_wen(a_req_wen),
    .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_rd_wen(a_out_rd_wen), .err(a_err)
  );

  lsu_mem_stage #(.TIMEOUT_CYC(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_result(in_result), .in_wdata(in_wdata),
    .in_read(in_read), .in_write(in_write), .in_reg_wen(in_reg_wen), .in_size(in_size),
    .in_unsigned(in_unsigned),
    .req_valid(b_req_valid), .req_ready(req_ready), .req_addr(b_req_addr), .req_wen(b_req_wen),
    .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_rd_wen(b_out_rd_wen), .err(b_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 0; in_read = 0; in_write = 0; in_reg_wen = 0; in_unsigned = 0;
    in_result = 0; in_wdata = 0; in_size = 0;
    req_ready = 0; resp_valid = 0; resp_rdata = 0; out_ready = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    in_valid = 1; in_read = rd; in_write = wr; in_size = sz; in_unsigned = uns;
    in_result = addr; in_wdata = wdata; in_reg_wen = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic out_handshake(input string tag);
    out_ready = 1;
    tick();
    out_ready = 0;
    check({tag, ".ovalid_after"}, 32'(m_out_valid), 32'd0);
    check({tag, ".iready_after"}, 32'(m_in_ready), 32'd1);
  endtask

  // Full memory access with immediate req_ready and resp_valid.
  task automatic mem_txn(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_mask, input logic [31:0] e_wdata,
                         input logic [31:0] e_out, input logic e_rdwen);
    issue(rd, wr, sz, uns, addr, wdata);
    check({tag, ".req_valid"}, 32'(m_req_valid), 32'd1);
    check({tag, ".in_ready"}, 32'(m_in_ready), 32'd0);
    check({tag, ".req_addr"}, m_req_addr, e_addr);
    check({tag, ".req_wen"}, 32'(m_req_wen), 32'(wr));
    check({tag, ".req_wmask"}, 32'(m_req_wmask), 32'(e_mask));
    check({tag, ".req_wdata"}, m_req_wdata, e_wdata);
    req_ready = 1;
    tick();
    req_ready = 0;
    check({tag, ".req_drop"}, 32'(m_req_valid), 32'd0);
    check({tag, ".ovalid_early"}, 32'(m_out_valid), 32'd0);
    resp_valid = 1; resp_rdata = rdata;
    tick();
    resp_valid = 0;
    check({tag, ".out_valid"}, 32'(m_out_valid), 32'd1);
    check({tag, ".out_data"}, m_out_data, e_out);
    check({tag, ".out_rd_wen"}, 32'(m_out_rd_wen), 32'(e_rdwen));
    check({tag, ".err"}, 32'(m_err), 32'd0);
    out_handshake(tag);
  endtask

  // Op that must bypass memory and complete with err one cycle after acceptance.
  task automatic err_txn(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] e_out);
    issue(rd, wr, sz, 1'b0, addr, 32'h0);
    check({tag, ".out_valid"}, 32'(m_out_valid), 32'd1);
    check({tag, ".err"}, 32'(m_err), 32'd1);
    check({tag, ".out_rd_wen"}, 32'(m_out_rd_wen), 32'd0);
    check({tag, ".out_data"}, m_out_data, e_out);
    check({tag, ".no_req"}, 32'(m_req_valid), 32'd0);
    out_handshake(tag);
    check({tag, ".err_clr"}, 32'(m_err), 32'd0);
  endtask

  initial begin
    use_to = 0;
    do_reset();
    check("rst.in_ready", 32'(m_in_ready), 32'd1);
    check("rst.req_valid", 32'(m_req_valid), 32'd0);
    check("rst.out_valid", 32'(m_out_valid), 32'd0);
    check("rst.out_data", m_out_data, 32'd0);
    check("rst.err", 32'(m_err), 32'd0);

    // ALU passthrough
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0);
    check("alu.out_valid", 32'(m_out_valid), 32'd1);
    check("alu.out_data", m_out_data, 32'h0000_1234);
    check("alu.out_rd_wen", 32'(m_out_rd_wen), 32'd1);
    check("alu.no_req", 32'(m_req_valid), 32'd0);
    check("alu.err", 32'(m_err), 32'd0);
    out_handshake("alu");

    //       tag    rd wr size  uns addr          wdata         rdata         req_addr      mask     wdata        out           rdwen
    mem_txn("lbu", 1, 0, 2'b00, 1, 32'h8000_0003, 32'h0,        32'h80FF_0000, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000_0080, 1);
    mem_txn("lb",  1, 0, 2'b00, 0, 32'h8000_0003, 32'h0,        32'h80FF_0000, 32'h8000_0000, 4'b0000, 32'h0,        32'hFFFF_FF80, 1);
    mem_txn("lh",  1, 0, 2'b01, 0, 32'h1000_0002, 32'h0,        32'h8001_1234, 32'h1000_0000, 4'b0000, 32'h0,        32'hFFFF_8001, 1);
    mem_txn("lhu", 1, 0, 2'b01, 1, 32'h1000_0000, 32'h0,        32'h8001_F234, 32'h1000_0000, 4'b0000, 32'h0,        32'h0000_F234, 1);
    mem_txn("lw",  1, 0, 2'b10, 0, 32'h2000_0004, 32'h0,        32'hDEAD_BEEF, 32'h2000_0004, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1);
    mem_txn("sh",  0, 1, 2'b01, 0, 32'h8000_0102, 32'h0000_ABCD, 32'h0,        32'h8000_0100, 4'b1100, 32'hABCD_0000, 32'h8000_0102, 0);
    mem_txn("sb",  0, 1, 2'b00, 0, 32'h0000_0041, 32'h1234_5678, 32'h0,        32'h0000_0040, 4'b0010, 32'h3456_7800, 32'h0000_0041, 0);
    mem_txn("sw",  0, 1, 2'b10, 0, 32'h0000_0040, 32'h1234_5678, 32'h0,        32'h0000_0040, 4'b1111, 32'h1234_5678, 32'h0000_0040, 0);

    // Illegal encodings
    err_txn("rdwr", 1'b1, 1'b1, 2'b10, 32'hCAFE_0000, 32'hCAFE_0000);
    err_txn("sz11", 1'b1, 1'b0, 2'b11, 32'hCAFE_0010, 32'hCAFE_0010);

    // Misaligned accesses
`ifdef LSU_MISALIGN_CHECK_EN
    err_txn("mis_lw", 1'b1, 1'b0, 2'b10, 32'h8000_0002, 32'h8000_0002);
    err_txn("mis_sh", 1'b0, 1'b1, 2'b01, 32'h8000_0003, 32'h8000_0003);
`else
    mem_txn("mis_lw", 1, 0, 2'b10, 0, 32'h8000_0002, 32'h0, 32'hAABB_CCDD, 32'h8000_0000, 4'b0000, 32'h0, 32'h0000_AABB, 1);
    mem_txn("mis_sh", 0, 1, 2'b01, 0, 32'h8000_0003, 32'h0000_ABCD, 32'h0, 32'h8000_0000, 4'b1000, 32'hCD00_0000, 32'h8000_0003, 0);
`endif

    // Backpressure on both request and writeback sides
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    in_valid = 1; in_result = 32'h0000_0F00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.req_valid", 32'(m_req_valid), 32'd1);
      check("bp.req_addr", m_req_addr, 32'h0000_0100);
      check("bp.in_ready", 32'(m_in_ready), 32'd0);
    end
    req_ready = 1;
    tick();
    req_ready = 0;
    resp_valid = 1; resp_rdata = 32'h0BAD_F00D;
    tick();
    resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("bp.out_valid", 32'(m_out_valid), 32'd1);
      check("bp.out_data", m_out_data, 32'h0BAD_F00D);
      check("bp.in_ready_out", 32'(m_in_ready), 32'd0);
      tick();
    end
    in_valid = 0;
    out_handshake("bp");
    check("bp.no_second_req", 32'(m_req_valid), 32'd0);

    // Timeout on the TIMEOUT_CYC=4 instance
    do_reset();
    use_to = 1;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    req_ready = 1;
    tick();
    req_ready = 0;
    check("to.in_resp", 32'(m_req_valid), 32'd0);
    tick();
    tick();
    check("to.not_yet", 32'(m_out_valid), 32'd0);
    tick();
    check("to.out_valid", 32'(m_out_valid), 32'd1);
    check("to.err", 32'(m_err), 32'd1);
    check("to.out_data", m_out_data, 32'd0);
    check("to.out_rd_wen", 32'(m_out_rd_wen), 32'd0);
    check("to.req_valid", 32'(m_req_valid), 32'd0);
    resp_valid = 1; resp_rdata = 32'h5555_5555;
    tick();
    resp_valid = 0;
    check("to.stray_data", m_out_data, 32'd0);
    check("to.stray_err", 32'(m_err), 32'd1);
    out_handshake("to");
    check("to.err_clr", 32'(m_err), 32'd0);
    resp_valid = 1;
    tick();
    resp_valid = 0;
    check("to.idle_stray", 32'(m_out_valid), 32'd0);
    mem_txn("to_next", 1, 0, 2'b10, 0, 32'h0000_0300, 32'h0, 32'h1122_3344, 32'h0000_0300, 4'b0000, 32'h0, 32'h1122_3344, 1);

    // Reset while waiting for a response
    do_reset();
    use_to = 0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
    req_ready = 1;
    tick();
    req_ready = 0;
    rst_n = 0;
    tick();
    check("rstmid.req_valid", 32'(m_req_valid), 32'd0);
    check("rstmid.out_valid", 32'(m_out_valid), 32'd0);
    check("rstmid.in_ready", 32'(m_in_ready), 32'd1);
    rst_n = 1;
    resp_valid = 1; resp_rdata = 32'h7777_7777;
    tick();
    resp_valid = 0;
    check("rstmid.stray", 32'(m_out_valid), 32'd0);
    check("rstmid.idle", 32'(m_in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
